load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator-side counterpart of the data memory/peripheral decoder. Sits between the core's execute stage and the doubleword-wide memory interface.
- Accepts one load/store request at a time and drives the memory interface's wen/ren/address/write-data.
- Converts byte/half/word/dword accesses to aligned doubleword transactions: read-modify-write for sub-dword stores; lane extraction and sign/zero extension for loads.

Parameters:
- WIDTH, 64, data/address width; must be 64 (dword lanes via addr[2:0]).
- MEM_LAT, 1, cycles from mem_ren high to mem_rdata valid; legal values 1 or 2.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept (high only in IDLE)
- req_we  input  1  1=store, 0=load
- req_size  input  2  00 byte, 01 half, 10 word, 11 dword
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
- req_addr  input  WIDTH  byte address
- req_wdata  input  WIDTH  store data, right-justified
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  WIDTH  extended load data; 0 for stores
- rsp_err  output  1  misaligned access (only with the optional feature)
- mem_wen  output  1  write enable to the memory interface
- mem_ren  output  1  read enable to the memory interface
- mem_addr  output  WIDTH  dword-aligned address; req_addr with bits [2:0] forced to 0
- mem_wdata  output  WIDTH  full dword write data
- mem_rdata  input  WIDTH  read data from the memory interface

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs 0 except req_ready=1. Any in-flight access is abandoned. mem_wen is never high while reset is high. Deassertion takes effect on the next clk edge.
- Handshake: accept on a clk edge with req_valid&req_ready. All request fields are latched at that edge, so inputs may change afterwards. req_ready=0 from the cycle after accept until the cycle after the rsp_valid cycle.
- Response: rsp_valid is high for exactly one cycle, in RESP. rsp_rdata and rsp_err are valid only in that cycle and are held at 0 otherwise. There is no response backpressure.
- States: IDLE, RD, RDW, WR, RESP.
- IDLE: on accept:
  - load -> RD;
  - store with size=11 -> WR;
  - store with size<11 -> RD.
- RD: mem_ren=1, mem_addr=latched aligned address, for one cycle.
- RDW: waits MEM_LAT-1 further cycles, then captures mem_rdata. Then:
  - load -> RESP;
  - sub-dword store -> WR.
- WR: mem_wen=1, mem_addr=aligned address, for exactly one cycle. mem_wdata is:
  - size=11: req_wdata;
  - otherwise: the captured dword with bytes [off .. off+n-1] replaced by req_wdata[8n-1:0], where off=addr[2:0] and n=1/2/4. Little-endian.
  - Then -> RESP.
- RESP: rsp_valid=1, then -> IDLE.
- Load extraction: field = captured dword >> (8*off), truncated to n bytes (n=8 for dword). Sign-extend from bit 8n-1 unless req_unsigned. Dword loads ignore req_unsigned.
- Latency from accept edge to rsp_valid cycle (MEM_LAT=1):
  - load: 3 cycles;
  - dword store: 2 cycles;
  - sub-dword store: 4 cycles.
  - Add MEM_LAT-1 to any path through RDW.
- mem_ren and mem_wen are never high in the same cycle. mem_wdata=0 whenever mem_wen=0.
- Misalignment means off is not a multiple of n.
  - Without the optional feature: off is honoured where the access fits the dword. If off+n>8, the access is truncated at byte 7 (upper bytes dropped, no wrap into the next dword).

Optional Feature:
- MISALIGN_TRAP_EN. When defined:
  - a misaligned request is accepted and goes IDLE -> RESP directly;
  - no mem_ren or mem_wen is issued;
  - rsp_err=1 and rsp_rdata=0 in the RESP cycle.
- When undefined: rsp_err is tied to 0 and truncation rules apply.

Test Plan:
- Dword store then load: store addr=0x10, data=0x1122334455667788, size=11 -> one mem_wen pulse at mem_addr=0x10, rsp 2 cycles after accept. Then load size=11 -> rsp_rdata=0x1122334455667788, 3 cycles after accept.
- Byte store RMW: mem dword at 0x08 holds 0xFFFFFFFFFFFFFFFF; store byte 0xA5 to 0x0B -> mem_ren then mem_wen, mem_wdata=0xFFFFFFFFA5FFFFFF, mem_ren/mem_wen never concurrent.
- Sign/zero extension: dword at 0x20 = 0x0000000080000000; load word signed 0x20 -> 0xFFFFFFFF80000000; unsigned -> 0x0000000080000000; half signed at 0x22 -> 0xFFFFFFFFFFFF8000.
- Back-to-back requests: req_valid held high with two loads -> req_ready low until the cycle after the first rsp_valid; second accepted exactly then; both responses correct.
- Reset mid-operation: assert reset during WR of a sub-dword store -> mem_wen falls immediately (async), all outputs 0, req_ready=1; no rsp_valid is produced for the aborted request.
- Misaligned half to 0x21 with MISALIGN_TRAP_EN -> rsp_err=1, rsp_rdata=0, no mem_ren/mem_wen, rsp 1 cycle after accept. Without the macro -> normal 3-cycle load with rsp_err=0.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response and memory-side signals of the load/store unit.
// slave: the unit itself; master: the core and memory environment around it.
interface load_store_unit_if #(
  parameter int unsigned WIDTH = 64
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;
  logic             mem_wen;
  logic             mem_ren;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_wen, mem_ren, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_wen, mem_ren, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte..dword accesses mapped onto an aligned dword memory interface.
// Optional MISALIGN_TRAP_EN: misaligned requests return rsp_err without touching memory.
module load_store_unit #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StRd, StRdw, StWr, StResp} state_e;

  state_e           state;
  logic             we_q;
  logic             uns_q;
  logic [1:0]       size_q;
  logic [2:0]       off_q;
  logic [1:0]       wait_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             trap;

  // Replace bytes [off .. off+n-1] of the old dword; bytes past 7 are dropped.
  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                        input logic [1:0] size, input logic [2:0] off);
    logic [63:0] r;
    int          o;
    int          n;
    r = old;
    o = int'(off);
    n = 1 << size;
    for (int i = 0; i < 8; i++) begin
      if (i >= o && i < o + n) r[8*i +: 8] = wd[8*(i-o) +: 8];
    end
    return r;
  endfunction

  function automatic logic [63:0] extract(input logic [63:0] rd, input logic [1:0] size,
                                          input logic [2:0] off, input logic uns);
    logic [63:0] f;
    f = rd >> {off, 3'b000};
    case (size)
      2'b00:   f = uns ? {56'd0, f[7:0]}  : {{56{f[7]}}, f[7:0]};
      2'b01:   f = uns ? {48'd0, f[15:0]} : {{48{f[15]}}, f[15:0]};
      2'b10:   f = uns ? {32'd0, f[31:0]} : {{32{f[31]}}, f[31:0]};
      default: ;
    endcase
    return f;
  endfunction

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    case (bus.req_size)
      2'b01:   trap = bus.req_addr[0];
      2'b10:   trap = |bus.req_addr[1:0];
      2'b11:   trap = |bus.req_addr[2:0];
      default: trap = 1'b0;
    endcase
  end
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= StIdle;
      we_q          <= 1'b0;
      uns_q         <= 1'b0;
      size_q        <= 2'b00;
      off_q         <= 3'd0;
      wait_q        <= 2'd0;
      addr_q        <= '0;
      wdata_q       <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.mem_wen   <= 1'b0;
      bus.mem_ren   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (bus.req_valid) begin
            we_q          <= bus.req_we;
            uns_q         <= bus.req_unsigned;
            size_q        <= bus.req_size;
            off_q         <= bus.req_addr[2:0];
            addr_q        <= {bus.req_addr[WIDTH-1:3], 3'b000};
            wdata_q       <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            if (trap) begin
              state         <= StResp;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
            end else if (bus.req_we && bus.req_size == 2'b11) begin
              state         <= StWr;
              bus.mem_wen   <= 1'b1;
              bus.mem_addr  <= {bus.req_addr[WIDTH-1:3], 3'b000};
              bus.mem_wdata <= bus.req_wdata;
            end else begin
              state        <= StRd;
              bus.mem_ren  <= 1'b1;
              bus.mem_addr <= {bus.req_addr[WIDTH-1:3], 3'b000};
            end
          end
        end
        StRd: begin
          state        <= StRdw;
          bus.mem_ren  <= 1'b0;
          bus.mem_addr <= '0;
          wait_q       <= 2'(MEM_LAT - 1);
        end
        // Read data is sampled directly off the bus on the last RDW cycle.
        StRdw: begin
          if (wait_q != 2'd0) begin
            wait_q <= wait_q - 2'd1;
          end else if (we_q) begin
            state         <= StWr;
            bus.mem_wen   <= 1'b1;
            bus.mem_addr  <= addr_q;
            bus.mem_wdata <= merge(bus.mem_rdata, wdata_q, size_q, off_q);
          end else begin
            state         <= StResp;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= extract(bus.mem_rdata, size_q, off_q, uns_q);
          end
        end
        StWr: begin
          state         <= StResp;
          bus.mem_wen   <= 1'b0;
          bus.mem_addr  <= '0;
          bus.mem_wdata <= '0;
          bus.rsp_valid <= 1'b1;
        end
        StResp: begin
          state         <= StIdle;
          bus.rsp_valid <= 1'b0;
          bus.rsp_rdata <= '0;
          bus.rsp_err   <= 1'b0;
          bus.req_ready <= 1'b1;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a one-cycle-latency dword memory model.
module tb_load_store_unit;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk;
  logic reset;
  load_store_unit_if #(.WIDTH(64)) bus ();

  load_store_unit #(.WIDTH(64), .MEM_LAT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] mem [0:15];
  always @(posedge clk) begin
    if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_addr[6:3]];
    if (bus.mem_wen) mem[bus.mem_addr[6:3]] <= bus.mem_wdata;
  end

  // Protocol monitor: pulse counts plus sticky violation count.
  int          ren_cnt = 0;
  int          wen_cnt = 0;
  int          viol    = 0;
  logic [63:0] last_waddr = '0;
  logic [63:0] last_wdata = '0;
  always @(negedge clk) begin
    if (bus.mem_ren && bus.mem_wen) viol++;
    if (!bus.mem_wen && bus.mem_wdata != 64'd0) viol++;
    if (!bus.rsp_valid && (bus.rsp_rdata != 64'd0 || bus.rsp_err)) viol++;
    if (bus.mem_ren) ren_cnt++;
    if (bus.mem_wen) begin
      wen_cnt++;
      last_waddr = bus.mem_addr;
      last_wdata = bus.mem_wdata;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [63:0] wd;
    logic        err;
    int          lat;
    int          nren;
    int          nwen;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [63:0] rdata, input logic [63:0] wd,
                              input logic mis);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.wd = wd; v.err = 1'b0;
    v.lat  = (we && size == 2'b11) ? 2 : (we ? 4 : 3);
    v.nren = (we && size == 2'b11) ? 0 : 1;
    v.nwen = we ? 1 : 0;
    if (mis && TRAP) begin
      v.err = 1'b1; v.rdata = '0; v.lat = 1; v.nren = 0; v.nwen = 0;
    end
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int r0, w0, lat;
    bit got;
    @(negedge clk);
    check({tag, " ready"}, 64'(bus.req_ready), 64'd1);
    r0 = ren_cnt;
    w0 = wen_cnt;
    bus.req_we = v.we; bus.req_size = v.size; bus.req_unsigned = v.uns;
    bus.req_addr = v.addr; bus.req_wdata = v.wdata; bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    // Scramble the request fields: the unit must work from its latched copy.
    bus.req_valid = 1'b0; bus.req_we = ~v.we; bus.req_size = ~v.size;
    bus.req_unsigned = ~v.uns; bus.req_addr = v.addr ^ 64'h2d; bus.req_wdata = ~v.wdata;
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = 1'b1;
        lat = c;
        check({tag, " rdata"}, bus.rsp_rdata, v.rdata);
        check({tag, " err"}, 64'(bus.rsp_err), 64'(v.err));
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(v.lat));
    check({tag, " ren pulses"}, 64'(ren_cnt - r0), 64'(v.nren));
    check({tag, " wen pulses"}, 64'(wen_cnt - w0), 64'(v.nwen));
    if (v.nwen != 0) begin
      check({tag, " wdata"}, last_wdata, v.wd);
      check({tag, " waddr"}, last_waddr, {v.addr[63:3], 3'b000});
    end
  endtask

  vec_t vecs [16];
  int   rsp_cyc [$];
  logic [63:0] rsp_dat [$];
  bit   rdy [0:15];
  bit   found;
  bit   got;

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0;

    vecs[0]  = mk(1, 2'b11, 0, 64'h10, 64'h1122334455667788, 64'h0, 64'h1122334455667788, 0);
    vecs[1]  = mk(0, 2'b11, 0, 64'h10, 64'h0, 64'h1122334455667788, 64'h0, 0);
    vecs[2]  = mk(1, 2'b11, 0, 64'h08, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFFFFF, 0);
    vecs[3]  = mk(1, 2'b00, 0, 64'h0B, 64'h123456789ABCDEA5, 64'h0, 64'hFFFFFFFFA5FFFFFF, 0);
    vecs[4]  = mk(0, 2'b00, 1, 64'h0B, 64'h0, 64'h00000000000000A5, 64'h0, 0);
    vecs[5]  = mk(0, 2'b00, 0, 64'h0B, 64'h0, 64'hFFFFFFFFFFFFFFA5, 64'h0, 0);
    vecs[6]  = mk(1, 2'b11, 0, 64'h20, 64'h0000000080000000, 64'h0, 64'h0000000080000000, 0);
    vecs[7]  = mk(0, 2'b10, 0, 64'h20, 64'h0, 64'hFFFFFFFF80000000, 64'h0, 0);
    vecs[8]  = mk(0, 2'b10, 1, 64'h20, 64'h0, 64'h0000000080000000, 64'h0, 0);
    vecs[9]  = mk(0, 2'b01, 0, 64'h22, 64'h0, 64'hFFFFFFFFFFFF8000, 64'h0, 0);
    vecs[10] = mk(1, 2'b01, 0, 64'h16, 64'hCAFEF00D00001234, 64'h0, 64'h1234334455667788, 0);
    vecs[11] = mk(0, 2'b10, 1, 64'h14, 64'h0, 64'h0000000012343344, 64'h0, 0);
    vecs[12] = mk(1, 2'b10, 0, 64'h0E, 64'hDEADBEEF, 64'h0, 64'hBEEFFFFFA5FFFFFF, 1);
    vecs[13] = mk(0, 2'b10, 0, 64'h0E, 64'h0, 64'h000000000000BEEF, 64'h0, 1);
    vecs[14] = mk(0, 2'b01, 0, 64'h21, 64'h0, 64'h0, 64'h0, 1);
    vecs[15] = mk(1, 2'b11, 0, 64'h18, 64'h0, 64'h0, 64'h0, 0);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset ready", 64'(bus.req_ready), 64'd1);
    check("reset ren", 64'(bus.mem_ren), 64'd0);
    check("reset wen", 64'(bus.mem_wen), 64'd0);
    check("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset mem_addr", bus.mem_addr, 64'd0);

    for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Back-to-back loads with req_valid held high.
    @(negedge clk);
    bus.req_we = 1'b0; bus.req_size = 2'b11; bus.req_unsigned = 1'b0;
    bus.req_addr = 64'h10; bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_size = 2'b10; bus.req_unsigned = 1'b1; bus.req_addr = 64'h20;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      rdy[c] = bus.req_ready;
      if (bus.rsp_valid) begin
        rsp_cyc.push_back(c);
        rsp_dat.push_back(bus.rsp_rdata);
      end
      if (bus.req_ready && bus.req_valid) begin
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    check("b2b ready at first rsp", 64'(rdy[3]), 64'd0);
    check("b2b ready after first rsp", 64'(rdy[4]), 64'd1);
    check("b2b rsp count", 64'(rsp_cyc.size()), 64'd2);
    if (rsp_cyc.size() == 2) begin
      check("b2b rsp0 cycle", 64'(rsp_cyc[0]), 64'd3);
      check("b2b rsp0 data", rsp_dat[0], 64'h1234334455667788);
      check("b2b rsp1 cycle", 64'(rsp_cyc[1]), 64'd7);
      check("b2b rsp1 data", rsp_dat[1], 64'h0000000080000000);
    end
    for (int c = 0; c < 20 && !bus.req_ready; c++) @(negedge clk);

    // Reset asserted while the sub-dword store is in WR.
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_size = 2'b00; bus.req_addr = 64'h18;
    bus.req_wdata = 64'h77; bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    found = 1'b0;
    for (int c = 1; c <= 10 && !found; c++) begin
      @(negedge clk);
      if (bus.mem_wen) found = 1'b1;
    end
    check("abort wen reached", 64'(found), 64'd1);
    reset = 1'b1;
    #1;
    check("abort wen", 64'(bus.mem_wen), 64'd0);
    check("abort ren", 64'(bus.mem_ren), 64'd0);
    check("abort wdata", bus.mem_wdata, 64'd0);
    check("abort ready", 64'(bus.req_ready), 64'd1);
    check("abort rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    got = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid) got = 1'b1;
    end
    check("abort no rsp", 64'(got), 64'd0);
    run_vec(mk(0, 2'b00, 1, 64'h18, 64'h0, 64'h0, 64'h0, 0), "abort readback");

    check("protocol violations", 64'(viol), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
